uart_c2f_bridge: RTL and testbench
==================================

UART_C2F_BRIDGE -- requirements
Module: uart_c2f_bridge

Interface
REQ-001 Parameter RSP_TIMEOUT, default 1024, max cycles spent waiting for a read response.
REQ-002 Parameter THREAD_ID, default 2'd0, value driven on C2F_ReqThreadIDQ500H and matched on responses.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rstn  input  1  reset, asynchronous assert, active-low.
REQ-005 rx_valid  input  1  byte from gateway UART receive path valid.
REQ-006 rx_data  input  8  received byte.
REQ-007 rx_ready  output  1  bridge accepts rx_data this cycle.
REQ-008 tx_valid  output  1  byte to gateway UART transmit path valid.
REQ-009 tx_data  output  8  byte to transmit.
REQ-010 tx_ready  input  1  gateway accepts tx_data this cycle.
REQ-011 C2F_ReqValidQ500H / C2F_ReqOpcodeQ500H(t_opcode) / C2F_ReqThreadIDQ500H[1:0] / C2F_ReqAddressQ500H[31:0] / C2F_ReqDataQ500H[31:0]  outputs  fabric request.
REQ-012 C2F_RspValidQ502H / C2F_RspOpcodeQ502H(t_opcode) / C2F_RspThreadIDQ502H[1:0] / C2F_RspDataQ502H[31:0] / C2F_RspStall  inputs  fabric response and back-pressure.

Function
REQ-013 Byte transfer occurs only when valid and ready are both high in the same cycle (rx and tx alike).
REQ-014 FSM states SHALL be IDLE, ADDR, DATA, ISSUE, WAIT_RSP, SEND.
REQ-015 rx_ready high only in IDLE, ADDR, DATA; low in all other states.
REQ-016 IDLE: 0x57 ('W') -> cmd=WR, go ADDR; 0x52 ('R') -> cmd=RD, go ADDR; any other byte -> load response 0x3F ('?'), go SEND.
REQ-017 ADDR: accept 4 bytes MSB first into address register; 2-bit byte counter; after 4th byte go DATA if WR, ISSUE if RD.
REQ-018 DATA: accept 4 bytes MSB first into data register; after 4th byte go ISSUE.
REQ-019 ISSUE: C2F_ReqValidQ500H high for exactly one cycle, in first cycle with C2F_RspStall low; held low while stall high; address/data/opcode/thread stable throughout ISSUE.
REQ-020 Request outputs: opcode WR or RD, thread THREAD_ID, data = data register (0 for RD); ReqValid low outside ISSUE.
REQ-021 WR: after issue cycle, load response 0x4B ('K'), go SEND (posted write; no response awaited).
REQ-022 RD: after issue cycle go WAIT_RSP, clear timeout counter.
REQ-023 WAIT_RSP: response accepted when C2F_RspValidQ502H high, opcode RD_RSP, thread = THREAD_ID; load 'D' followed by the 4 response data bytes MSB first (5 bytes), go SEND.
REQ-024 WAIT_RSP: responses with other opcode or thread ignored.
REQ-025 WAIT_RSP: counter increments each cycle; at RSP_TIMEOUT cycles with no match, load 0x54 ('T') as the single response byte, go SEND; a matching response in the same cycle the counter expires wins.
REQ-026 SEND: tx_valid high, tx_data stable until handshake; byte counter advances per handshake; after final byte go IDLE.
REQ-027 tx_valid low outside SEND; no rx byte consumed while in SEND.
REQ-028 Minimum read latency: ReqValid cycle to first tx_valid = response arrival cycle + 1.

Reset
REQ-029 rstn low: state IDLE; all counters, address, data and response registers 0; rx_ready 1 after release; tx_valid 0; C2F_ReqValidQ500H 0; other request outputs 0.
REQ-030 Reset mid-frame or mid-response abandons the transaction; no partial request or byte is emitted after release.

Verification
REQ-031 Write: rx 57 10 00 00 04 DE AD BE EF -> one ReqValid, WR, addr 0x10000004, data 0xDEADBEEF; tx 4B.
REQ-032 Read: rx 52 00 00 00 08; RD_RSP data 0x12345678 three cycles later -> tx 44 12 34 56 78.
REQ-033 Stall: RspStall held high 5 cycles during ISSUE -> ReqValid stays low, asserts once on first low cycle.
REQ-034 Timeout: read with no response, RSP_TIMEOUT=16 -> tx 54 after 16 WAIT_RSP cycles; late response ignored.
REQ-035 Bad command rx 41 -> tx 3F; wrong-thread RD_RSP ignored; tx_ready low 10 cycles holds tx_data stable.
REQ-036 Reset asserted after 2 address bytes -> no request issued; next full frame processed normally.

Source files
------------

// File: rtl/uart_c2f_bridge.sv
// uart_c2f_bridge
//   Turns a byte stream from a gateway UART into single fabric transactions
//   and sends a short byte reply back on the UART transmit path.
//   Frames accepted on rx:
//     'W' a3 a2 a1 a0 d3 d2 d1 d0  -> posted write, reply 'K'
//     'R' a3 a2 a1 a0              -> read, reply 'D' r3 r2 r1 r0, or 'T' on timeout
//     any other first byte         -> reply '?'
//   Ports:
//     clk, rstn                      clock, async active-low reset
//     rx_valid/rx_ready/rx_data      receive byte handshake (bridge is sink)
//     tx_valid/tx_ready/tx_data      transmit byte handshake (bridge is source)
//     C2F_Req*Q500H                  fabric request, one-cycle valid pulse
//     C2F_Rsp*Q502H, C2F_RspStall    fabric response and request back-pressure

package uart_c2f_pkg;
    typedef enum logic [1:0] {
        OP_NONE   = 2'd0,
        OP_WR     = 2'd1,
        OP_RD     = 2'd2,
        OP_RD_RSP = 2'd3
    } t_opcode;
endpackage

module uart_c2f_bridge
    import uart_c2f_pkg::*;
#(
    parameter int          RSP_TIMEOUT = 1024,
    parameter logic [1:0]  THREAD_ID   = 2'd0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        C2F_ReqValidQ500H,
    output t_opcode     C2F_ReqOpcodeQ500H,
    output logic [1:0]  C2F_ReqThreadIDQ500H,
    output logic [31:0] C2F_ReqAddressQ500H,
    output logic [31:0] C2F_ReqDataQ500H,
    input  logic        C2F_RspValidQ502H,
    input  t_opcode     C2F_RspOpcodeQ502H,
    input  logic [1:0]  C2F_RspThreadIDQ502H,
    input  logic [31:0] C2F_RspDataQ502H,
    input  logic        C2F_RspStall
);

    localparam int TW = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(RSP_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, ADDR, DATA, ISSUE, WAIT_RSP, SEND
    } t_state;

    t_state         state_q,   state_d;
    t_opcode        cmd_q,     cmd_d;
    logic [1:0]     cnt_q,     cnt_d;
    logic [31:0]    addr_q,    addr_d;
    logic [31:0]    data_q,    data_d;
    // Reply bytes leave from the top of rsp_q; rsp_len_q counts what is left.
    logic [39:0]    rsp_q,     rsp_d;
    logic [2:0]     rsp_len_q, rsp_len_d;
    logic [TW-1:0]  tmo_q,     tmo_d;

    logic rsp_match;
    assign rsp_match = C2F_RspValidQ502H && (C2F_RspOpcodeQ502H == OP_RD_RSP)
                    && (C2F_RspThreadIDQ502H == THREAD_ID);

    always_comb begin
        state_d           = state_q;
        cmd_d             = cmd_q;
        cnt_d             = cnt_q;
        addr_d            = addr_q;
        data_d            = data_q;
        rsp_d             = rsp_q;
        rsp_len_d         = rsp_len_q;
        tmo_d             = tmo_q;
        rx_ready          = 1'b0;
        tx_valid          = 1'b0;
        C2F_ReqValidQ500H = 1'b0;

        case (state_q)
            IDLE: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    cnt_d  = 2'd0;
                    // Data register is cleared so a read presents zero data.
                    data_d = 32'h0;
                    if (rx_data == 8'h57) begin
                        cmd_d   = OP_WR;
                        state_d = ADDR;
                    end else if (rx_data == 8'h52) begin
                        cmd_d   = OP_RD;
                        state_d = ADDR;
                    end else begin
                        rsp_d     = {8'h3F, 32'h0};
                        rsp_len_d = 3'd1;
                        state_d   = SEND;
                    end
                end
            end
            ADDR: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    addr_d = {addr_q[23:0], rx_data};
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3)
                        state_d = (cmd_q == OP_WR) ? DATA : ISSUE;
                end
            end
            DATA: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    data_d = {data_q[23:0], rx_data};
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3)
                        state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!C2F_RspStall) begin
                    C2F_ReqValidQ500H = 1'b1;
                    if (cmd_q == OP_WR) begin
                        rsp_d     = {8'h4B, 32'h0};
                        rsp_len_d = 3'd1;
                        state_d   = SEND;
                    end else begin
                        tmo_d   = '0;
                        state_d = WAIT_RSP;
                    end
                end
            end
            WAIT_RSP: begin
                // A match in the expiry cycle takes priority over the timeout.
                if (rsp_match) begin
                    rsp_d     = {8'h44, C2F_RspDataQ502H};
                    rsp_len_d = 3'd5;
                    state_d   = SEND;
                end else if (tmo_q == TMO_LAST) begin
                    rsp_d     = {8'h54, 32'h0};
                    rsp_len_d = 3'd1;
                    state_d   = SEND;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            SEND: begin
                tx_valid = 1'b1;
                if (tx_ready) begin
                    rsp_d     = {rsp_q[31:0], 8'h0};
                    rsp_len_d = rsp_len_q - 3'd1;
                    if (rsp_len_q == 3'd1)
                        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            cmd_q     <= OP_NONE;
            cnt_q     <= 2'd0;
            addr_q    <= 32'h0;
            data_q    <= 32'h0;
            rsp_q     <= 40'h0;
            rsp_len_q <= 3'd0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            rsp_q     <= rsp_d;
            rsp_len_q <= rsp_len_d;
            tmo_q     <= tmo_d;
        end
    end

    assign tx_data              = rsp_q[39:32];
    assign C2F_ReqOpcodeQ500H   = cmd_q;
    assign C2F_ReqThreadIDQ500H = THREAD_ID;
    assign C2F_ReqAddressQ500H  = addr_q;
    assign C2F_ReqDataQ500H     = data_q;

endmodule

// File: tb/tb_uart_c2f_bridge.sv
// Directed bench for uart_c2f_bridge: write, read, stall, timeout,
// bad command, wrong-thread response, tx back-pressure, reset mid-frame.
module tb_uart_c2f_bridge;
    import uart_c2f_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        rx_valid, rx_ready, tx_valid, tx_ready;
    logic [7:0]  rx_data, tx_data;
    logic        req_valid, rsp_valid, rsp_stall;
    t_opcode     req_op, rsp_op;
    logic [1:0]  req_thr, rsp_thr;
    logic [31:0] req_addr, req_data, rsp_data;

    always #5 clk = ~clk;

    uart_c2f_bridge #(.RSP_TIMEOUT(16), .THREAD_ID(2'd0)) dut (
        .clk(clk), .rstn(rstn),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .C2F_ReqValidQ500H(req_valid), .C2F_ReqOpcodeQ500H(req_op),
        .C2F_ReqThreadIDQ500H(req_thr), .C2F_ReqAddressQ500H(req_addr),
        .C2F_ReqDataQ500H(req_data),
        .C2F_RspValidQ502H(rsp_valid), .C2F_RspOpcodeQ502H(rsp_op),
        .C2F_RspThreadIDQ502H(rsp_thr), .C2F_RspDataQ502H(rsp_data),
        .C2F_RspStall(rsp_stall)
    );

    int tests = 0;
    int fails = 0;

    // Monitor: samples on the falling edge, inputs change 1ns after rising.
    int          cyc = 0;
    int          req_cnt = 0;
    int          req_cyc = 0;
    int          tx_rise_cyc = 0;
    logic        tx_prev = 1'b0;
    logic [31:0] m_addr = '0, m_data = '0;
    t_opcode     m_op = OP_NONE;
    logic [1:0]  m_thr = '0;
    logic [7:0]  txq[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (req_valid) begin
            req_cnt++;
            req_cyc = cyc;
            m_addr  = req_addr;
            m_data  = req_data;
            m_op    = req_op;
            m_thr   = req_thr;
        end
        if (tx_valid && !tx_prev) tx_rise_cyc = cyc;
        tx_prev = tx_valid;
        if (tx_valid && tx_ready) txq.push_back(tx_data);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("rx_ready_timeout", 64'd0, 64'd1);
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic wait_tx(input int base, input int n, input string tag);
        int k;
        k = 0;
        while (txq.size() < base + n && k < 200) begin
            tick();
            k++;
        end
        chk(tag, 64'(txq.size() - base), 64'(n));
    endtask

    task automatic drive_rsp(input t_opcode op, input logic [1:0] thr, input logic [31:0] d);
        rsp_valid = 1'b1;
        rsp_op    = op;
        rsp_thr   = thr;
        rsp_data  = d;
        tick();
        rsp_valid = 1'b0;
        rsp_op    = OP_NONE;
    endtask

    initial begin
        int base;
        int r0;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        tx_ready  = 1'b1;
        rsp_valid = 1'b0;
        rsp_op    = OP_NONE;
        rsp_thr   = 2'd0;
        rsp_data  = 32'h0;
        rsp_stall = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_tx_valid", 64'(tx_valid), 64'd0);
        chk("rst_req_valid", 64'(req_valid), 64'd0);
        chk("rst_req_addr", 64'(req_addr), 64'd0);
        chk("rst_req_data", 64'(req_data), 64'd0);
        chk("rst_req_op", 64'(req_op), 64'd0);
        rstn = 1'b1;
        tick();
        chk("rst_rx_ready", 64'(rx_ready), 64'd1);

        // Write: 57 10 00 00 04 DE AD BE EF -> one WR request, reply 4B
        base = txq.size();
        r0   = req_cnt;
        send_byte(8'h57);
        send_word(32'h1000_0004);
        send_word(32'hDEAD_BEEF);
        repeat (2) tick();
        chk("wr_req_cnt", 64'(req_cnt - r0), 64'd1);
        chk("wr_req_op", 64'(m_op), 64'(OP_WR));
        chk("wr_req_addr", 64'(m_addr), 64'h1000_0004);
        chk("wr_req_data", 64'(m_data), 64'hDEAD_BEEF);
        chk("wr_req_thr", 64'(m_thr), 64'd0);
        wait_tx(base, 1, "wr_tx_count");
        chk("wr_tx_byte", 64'(txq[base]), 64'h4B);
        chk("wr_req_low_after", 64'(req_valid), 64'd0);
        chk("wr_idle_rx_ready", 64'(rx_ready), 64'd1);

        // Read: 52 00 00 00 08, RD_RSP 0x12345678 three cycles after ReqValid
        base = txq.size();
        r0   = req_cnt;
        send_byte(8'h52);
        send_word(32'h0000_0008);
        repeat (3) tick();
        drive_rsp(OP_RD_RSP, 2'd0, 32'h1234_5678);
        wait_tx(base, 5, "rd_tx_count");
        chk("rd_req_cnt", 64'(req_cnt - r0), 64'd1);
        chk("rd_req_op", 64'(m_op), 64'(OP_RD));
        chk("rd_req_addr", 64'(m_addr), 64'h0000_0008);
        chk("rd_req_data", 64'(m_data), 64'd0);
        chk("rd_latency", 64'(tx_rise_cyc - req_cyc), 64'd4);
        chk("rd_tx0", 64'(txq[base]), 64'h44);
        chk("rd_tx1", 64'(txq[base+1]), 64'h12);
        chk("rd_tx2", 64'(txq[base+2]), 64'h34);
        chk("rd_tx3", 64'(txq[base+3]), 64'h56);
        chk("rd_tx4", 64'(txq[base+4]), 64'h78);

        // Stall: RspStall high for 5 ISSUE cycles holds ReqValid low
        base = txq.size();
        r0   = req_cnt;
        rsp_stall = 1'b1;
        send_byte(8'h57);
        send_word(32'h0000_0100);
        send_word(32'hCAFE_F00D);
        for (int i = 0; i < 5; i++) begin
            chk("stall_req_low", 64'(req_valid), 64'd0);
            chk("stall_addr_stable", 64'(req_addr), 64'h0000_0100);
            tick();
        end
        chk("stall_no_req", 64'(req_cnt - r0), 64'd0);
        rsp_stall = 1'b0;
        #1;
        chk("stall_req_high", 64'(req_valid), 64'd1);
        tick();
        chk("stall_req_cnt", 64'(req_cnt - r0), 64'd1);
        chk("stall_req_data", 64'(m_data), 64'hCAFE_F00D);
        chk("stall_req_low_after", 64'(req_valid), 64'd0);
        wait_tx(base, 1, "stall_tx_count");
        chk("stall_tx_byte", 64'(txq[base]), 64'h4B);

        // Wrong-thread / wrong-opcode responses ignored, tx back-pressure
        base = txq.size();
        send_byte(8'h52);
        send_word(32'h0000_000C);
        tick();
        drive_rsp(OP_RD_RSP, 2'd1, 32'hAAAA_AAAA);
        drive_rsp(OP_WR, 2'd0, 32'hBBBB_BBBB);
        tick();
        chk("wt_no_tx", 64'(tx_valid), 64'd0);
        tx_ready = 1'b0;
        drive_rsp(OP_RD_RSP, 2'd0, 32'h8765_4321);
        for (int i = 0; i < 10; i++) begin
            chk("bp_tx_valid", 64'(tx_valid), 64'd1);
            chk("bp_tx_data", 64'(tx_data), 64'h44);
            tick();
        end
        chk("bp_no_consume", 64'(txq.size() - base), 64'd0);
        tx_ready = 1'b1;
        wait_tx(base, 5, "wt_tx_count");
        chk("wt_tx0", 64'(txq[base]), 64'h44);
        chk("wt_tx1", 64'(txq[base+1]), 64'h87);
        chk("wt_tx2", 64'(txq[base+2]), 64'h65);
        chk("wt_tx3", 64'(txq[base+3]), 64'h43);
        chk("wt_tx4", 64'(txq[base+4]), 64'h21);

        // Timeout: no response, reply 54 after 16 WAIT_RSP cycles
        base = txq.size();
        send_byte(8'h52);
        send_word(32'h0000_0020);
        wait_tx(base, 1, "tmo_tx_count");
        chk("tmo_tx_byte", 64'(txq[base]), 64'h54);
        chk("tmo_latency", 64'(tx_rise_cyc - req_cyc), 64'd17);
        drive_rsp(OP_RD_RSP, 2'd0, 32'h1111_1111);
        repeat (5) tick();
        chk("tmo_late_ignored", 64'(txq.size() - base), 64'd1);
        chk("tmo_tx_idle", 64'(tx_valid), 64'd0);
        chk("tmo_rx_ready", 64'(rx_ready), 64'd1);

        // Bad command
        base = txq.size();
        send_byte(8'h41);
        wait_tx(base, 1, "bad_tx_count");
        chk("bad_tx_byte", 64'(txq[base]), 64'h3F);

        // Reset after two address bytes abandons the frame
        base = txq.size();
        r0   = req_cnt;
        send_byte(8'h52);
        send_byte(8'h00);
        send_byte(8'h00);
        rstn = 1'b0;
        repeat (2) tick();
        chk("mid_rst_addr", 64'(req_addr), 64'd0);
        rstn = 1'b1;
        tick();
        chk("mid_rst_rx_ready", 64'(rx_ready), 64'd1);
        chk("mid_rst_tx_valid", 64'(tx_valid), 64'd0);
        repeat (3) tick();
        chk("mid_rst_no_req", 64'(req_cnt - r0), 64'd0);
        chk("mid_rst_no_tx", 64'(txq.size() - base), 64'd0);
        send_byte(8'h57);
        send_word(32'hABCD_EF01);
        send_word(32'h0000_0005);
        wait_tx(base, 1, "post_rst_tx_count");
        chk("post_rst_req_cnt", 64'(req_cnt - r0), 64'd1);
        chk("post_rst_addr", 64'(m_addr), 64'hABCD_EF01);
        chk("post_rst_data", 64'(m_data), 64'h0000_0005);
        chk("post_rst_tx", 64'(txq[base]), 64'h4B);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
